// File: rtl/updown_bcd_counter_pkg.sv
// Shared types and helpers for the two-digit up/down BCD counter.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Converts a decimal parameter (clamped to 0..99) into packed {tens, ones} BCD.
    function automatic logic [7:0] to_bcd(input int value);
        int v;
        v = (value > 99) ? 99 : ((value < 0) ? 0 : value);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/updown_bcd_counter_digit.sv
// Single BCD digit stepper: increments or decrements when i_cin is set and
// reports carry (9->0 going up) or borrow (0->9 going down) on o_cout.
module bcd_digit
    import cnt_pkg::*;
(
    input  bcd_t i_digit,
    input  logic i_up,
    input  logic i_cin,
    output bcd_t o_digit,
    output logic o_cout
);

    always_comb begin
        o_digit = i_digit;
        o_cout  = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_digit >= BCD_MAX) begin
                    o_digit = 4'd0;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit + 4'd1;
                end
            end else begin
                if (i_digit == 4'd0) begin
                    o_digit = BCD_MAX;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/updown_bcd_counter.sv
// Two-digit up/down BCD counter with load, pause and prescaled stepping.
// Define UPDOWN_BCD_WRAP_EN to wrap at the terminal values instead of stopping in DONE.
module updown_bcd_counter
    import cnt_pkg::*;
#(
    parameter int MAX_VAL = 99,
    parameter int DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_dir,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [3:0] o_cnt_tens,
    output logic [3:0] o_cnt_ones,
    output logic       o_tc,
    output logic       o_busy,
    output logic [1:0] o_state
);

    localparam logic [7:0]    MAX_BCD  = to_bcd(MAX_VAL);
    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_t        r_state, w_nextState;
    bcd_t          r_tens, r_ones, w_nextTens, w_nextOnes;
    logic          r_tc, w_nextTc;
    logic          r_busy;
    logic [PW-1:0] r_presc, w_nextPresc;

    bcd_t       w_ldTens, w_ldOnes, w_stepTens, w_stepOnes;
    logic [7:0] w_ldVal, w_ldClamped, w_cnt, w_step;
    logic       w_onesCarry, w_tensCarry, w_atTerm;

    // Per-digit clamp first, then clamp the whole value to the terminal value.
    assign w_ldTens    = (i_load_val[7:4] > BCD_MAX) ? BCD_MAX : i_load_val[7:4];
    assign w_ldOnes    = (i_load_val[3:0] > BCD_MAX) ? BCD_MAX : i_load_val[3:0];
    assign w_ldVal     = {w_ldTens, w_ldOnes};
    assign w_ldClamped = (w_ldVal > MAX_BCD) ? MAX_BCD : w_ldVal;

    assign w_cnt  = {r_tens, r_ones};
    assign w_step = {w_stepTens, w_stepOnes};

    bcd_digit u_ones (
        .i_digit (r_ones),
        .i_up    (i_dir),
        .i_cin   (1'b1),
        .o_digit (w_stepOnes),
        .o_cout  (w_onesCarry)
    );

    bcd_digit u_tens (
        .i_digit (r_tens),
        .i_up    (i_dir),
        .i_cin   (w_onesCarry),
        .o_digit (w_stepTens),
        .o_cout  (w_tensCarry)
    );

    // A tens borrow while counting down only happens from 00.
    assign w_atTerm = i_dir ? (w_cnt == MAX_BCD) : w_tensCarry;

`ifndef UPDOWN_BCD_WRAP_EN
    logic w_stepTerm;
    assign w_stepTerm = i_dir ? (w_step == MAX_BCD) : (w_step == 8'h00);
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextTens  = r_tens;
        w_nextOnes  = r_ones;
        w_nextTc    = 1'b0;
        w_nextPresc = r_presc;
        if (i_load) begin
            w_nextState = IDLE;
            {w_nextTens, w_nextOnes} = w_ldClamped;
            w_nextPresc = '0;
        end else begin
            case (r_state)
                IDLE: if (i_en) w_nextState = RUN;
                RUN: begin
                    if (!i_en) begin
                        w_nextState = HOLD;
                    end else if (r_presc != PRE_LAST) begin
                        w_nextPresc = r_presc + 1'b1;
                    end else begin
                        w_nextPresc = '0;
                        if (w_atTerm) begin
`ifdef UPDOWN_BCD_WRAP_EN
                            {w_nextTens, w_nextOnes} = i_dir ? 8'h00 : MAX_BCD;
                            w_nextTc = 1'b1;
`else
                            w_nextState = DONE;
                            w_nextTc    = 1'b1;
`endif
                        end else begin
                            {w_nextTens, w_nextOnes} = w_step;
`ifndef UPDOWN_BCD_WRAP_EN
                            if (w_stepTerm) begin
                                w_nextState = DONE;
                                w_nextTc    = 1'b1;
                            end
`endif
                        end
                    end
                end
                HOLD: if (i_en) w_nextState = RUN;
                default: w_nextState = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_tc    <= 1'b0;
            r_busy  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_state <= w_nextState;
            r_tens  <= w_nextTens;
            r_ones  <= w_nextOnes;
            r_tc    <= w_nextTc;
            r_busy  <= (w_nextState == RUN);
            r_presc <= w_nextPresc;
        end
    end

    assign o_cnt_tens = r_tens;
    assign o_cnt_ones = r_ones;
    assign o_tc       = r_tc;
    assign o_busy     = r_busy;
    assign o_state    = r_state;

endmodule

// File: doc/updown_bcd_counter.md
Name: updown_bcd_counter

Overview:
Two-digit BCD counter, complement to the team's 4-bit free-running down counter: counts up toward a terminal value or down toward 00, with load, pause and direction control.
A small FSM sequences idle/run/hold/done and exposes a one-cycle terminal-count pulse.
Sits between the board clock domain and the seven-segment driver / LED logic in lab timer designs.

Parameters:
MAX_VAL, 99, terminal value for up-counting (decimal 0..99, held internally as BCD)
DIV, 1, clock cycles per count step (>=1); 1 = step every clk

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  level: run when high, pause when low
dir  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe (one cycle)
load_val  in  8  BCD value {tens, ones} to load
cnt_tens  out  4  BCD tens digit
cnt_ones  out  4  BCD ones digit
tc  out  1  one-cycle pulse when terminal value reached
busy  out  1  high in RUN
state  out  2  FSM state code (debug)

Behaviour:
- Reset (rst low, async): state=IDLE, cnt_tens=0, cnt_ones=0, tc=0, busy=0, prescaler=0.
- All outputs registered; state encoding IDLE=0, RUN=1, HOLD=2, DONE=3.
- Priority per cycle: load > en/dir > stepping.
- load (any state): count <= clamped load_val; state <= IDLE; prescaler <= 0; tc <= 0.
  - Digit >9 clamps to 9 per digit.
  - Then value >MAX_VAL clamps to MAX_VAL.
- IDLE: en=1 -> RUN next cycle.
- RUN: en=0 -> HOLD. Otherwise prescaler increments; on prescaler==DIV-1, prescaler <= 0 and one step is taken.
- HOLD: count and prescaler frozen; en=1 -> RUN, prescaler resumes from held value.
- DONE: count frozen at terminal value; exits only on load.
- Step up: ones 9->0 with tens+1; otherwise ones+1.
- Step down: ones 0->9 with tens-1; otherwise ones-1.
- Terminal handling:
  - Step producing MAX_VAL (up) or 00 (down): state <= DONE and tc=1 in the same cycle the new value appears.
  - Entering RUN already at the terminal value for the current dir: the first step is suppressed; state <= DONE with tc=1 on that step tick.
- Latency: en rises in cycle N -> RUN at N+1 -> first count change visible at N+DIV+1.
- dir change while RUN/HOLD takes effect on the next step; no restart of the prescaler.
- tc high for exactly one cycle per terminal event; never high in IDLE/HOLD.
- Reset asserted mid-RUN: immediate return to reset values; no tc.

Optional Feature:
- Macro UPDOWN_BCD_WRAP_EN.
- Defined: no DONE entry.
  - Up: MAX_VAL steps to 00; down: 00 steps to MAX_VAL.
  - tc pulses one cycle on each wrap step; state stays RUN.
- Undefined: terminal behaviour as in Behaviour (stop in DONE).

Decomposition:
- Package cnt_pkg:
  - state enum (IDLE, RUN, HOLD, DONE)
  - bcd_t 4-bit digit typedef
  - constant BCD_MAX=4'd9
  - function to_bcd for MAX_VAL conversion
- Sub-module bcd_digit: one digit with inc/dec, carry-in/borrow-in and carry/borrow-out, instantiated twice (ones feeds tens).

Test Plan:
- Reset mid-run: en=1, DIV=1, 5 cycles, pulse rst low -> counts 00, state=IDLE, tc=0 immediately, no clk edge needed.
- Up count: DIV=1, MAX_VAL=99, dir=1, load 8'h07, en=1 -> 07,08,09,10 across tens carry; load 8'h97 -> 98,99, tc=1 with 99, state=DONE, count frozen.
- Down count: load 8'h12, dir=0, en=1 -> 11,10,09; load 8'h01 -> 00 with tc=1, then DONE.
- Prescale and pause: DIV=4, load 8'h00, dir=1, en=1 -> first change to 01 at cycle 5 after en. Drop en for 3 cycles -> value held, state=HOLD. Re-raise en -> resumes with no lost or extra step.
- Clamp and priority: MAX_VAL=59.
  - Load 8'hA3 -> 93 clamped to 59.
  - load and en high in the same cycle -> state=IDLE and value loaded.
  - en=1 then dir=1 -> immediate DONE with tc.
- Wrap (UPDOWN_BCD_WRAP_EN): MAX_VAL=59, load 8'h59, dir=1, en=1 -> 00 with tc=1, state stays RUN; dir=0 at 00 -> 59 with tc=1.
